// File: rtl/dispatcher_pkg.sv
// rtl/dispatcher_pkg.sv - shared state type and pointer-width helper for the round-robin dispatcher
package dispatcher_pkg;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} disp_state_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick_n.sv
// rtl/rr_pick_n.sv - combinational round-robin picker: first set candidate at or after start, wrapping
module rr_pick_n
  import dispatcher_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = ptr_w(N)
) (
  input  logic [N-1:0]     cand,
  input  logic [PTR_W-1:0] start,
  output logic [PTR_W-1:0] pick,
  output logic             found
);

  logic [N-1:0] rot;
  int           off;
  int           sum;

  // Rotate so that start lands on bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot   = N'({cand, cand} >> start);
    off   = 0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = k;
        found = 1'b1;
      end
    end
    sum = int'(start) + off;
    if (sum >= N) sum = sum - N;
    pick = PTR_W'(sum);
  end

endmodule

// File: rtl/dispatcher_rr_n.sv
// rtl/dispatcher_rr_n.sv - 1-to-N round-robin stream dispatcher with registered output and one-entry skid
module dispatcher_rr_n
  import dispatcher_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int N      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid [N-1:0],
  output logic [DWIDTH-1:0] out_data  [N-1:0],
  input  logic              out_ready [N-1:0]
);

  localparam int PTR_W = ptr_w(N);

  disp_state_t       state_q, state_d;
  logic [DWIDTH-1:0] oreg_q, oreg_d, skid_q, skid_d;
  logic [PTR_W-1:0]  sel_q, sel_d, ptr_q, ptr_d;
  logic [PTR_W-1:0]  start, pick, next_sel;
  logic [N-1:0]      ready_q, ready_vec;
  logic              in_ready_q, found, sel_ready;
  logic              in_fire, out_fire;
  logic              load_oreg, load_skid, oreg_from_skid;
  int                start_i;

  always_comb begin
    ready_vec = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      ready_vec[i] = out_ready[i];
      if (sel_q == PTR_W'(i)) sel_ready = out_ready[i];
    end
  end

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = (state_q != ST_EMPTY) & sel_ready;

  // Search begins one past the last winner; stale ready_q keeps outputs free of ready paths.
  always_comb begin
    start_i = int'(ptr_q) + 1;
    if (start_i >= N) start_i = 0;
    start = PTR_W'(start_i);
  end

  rr_pick_n #(.N(N), .PTR_W(PTR_W)) u_pick (
    .cand  (ready_q),
    .start (start),
    .pick  (pick),
    .found (found)
  );

  assign next_sel = found ? pick : start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      oreg_q     <= '0;
      skid_q     <= '0;
      sel_q      <= '0;
      ptr_q      <= PTR_W'(N - 1);
      ready_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      oreg_q     <= oreg_d;
      skid_q     <= skid_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      ready_q    <= ready_vec;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d        = state_q;
    load_oreg      = 1'b0;
    load_skid      = 1'b0;
    oreg_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d   = ST_ONE;
          load_oreg = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && !out_fire) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (out_fire && !in_fire) begin
          state_d = ST_EMPTY;
        end else if (in_fire && out_fire) begin
          load_oreg = 1'b1;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          state_d        = ST_ONE;
          oreg_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // A fresh target is chosen only when oreg takes a new item; otherwise sel stays frozen.
  always_comb begin
    oreg_d = oreg_q;
    skid_d = skid_q;
    sel_d  = sel_q;
    ptr_d  = ptr_q;
    if (load_oreg) oreg_d = in_data;
    else if (oreg_from_skid) oreg_d = skid_q;
    if (load_skid) skid_d = in_data;
    if (load_oreg || oreg_from_skid) begin
      sel_d = next_sel;
      ptr_d = next_sel;
    end
  end

  always_comb begin
    in_ready = in_ready_q;
    for (int i = 0; i < N; i++) begin
      out_valid[i] = (state_q != ST_EMPTY) && (sel_q == PTR_W'(i));
      out_data[i]  = oreg_q;
    end
  end

endmodule

// File: doc/dispatcher_rr_n.md
# dispatcher_rr_n

Round-robin 1-to-N stream dispatcher: the fan-out counterpart of the N-to-1 round-robin arbiter. It accepts one valid/ready stream and delivers each item to exactly one of N consumers (e.g. engines or cores), steering toward consumers that were recently ready. Items pass through a registered output stage plus a one-entry skid buffer, giving full throughput with protocol-clean outputs: no output is combinationally dependent on any ready input.

## Interface
- `DWIDTH`, 16, data width in bits.
- `N`, 2, number of output channels (≥1); `PTR_W = (N>1) ? $clog2(N) : 1`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset; all state clears immediately on assertion.
- `in_valid`  in  1  upstream item valid.
- `in_data`  in  DWIDTH  upstream item.
- `in_ready`  out  1  registered; high when the skid buffer is empty.
- `out_valid`  out  1 x [N-1:0] (unpacked)  at most one bit high at any time.
- `out_data`  out  DWIDTH x [N-1:0] (unpacked)  every channel carries the output register; meaningful only where `out_valid[i]` is high.
- `out_ready`  in  1 x [N-1:0] (unpacked)  consumer ready.

## Operation
- Handshakes: input transfer = `in_valid & in_ready`; output transfer on i = `out_valid[i] & out_ready[i]`.
- Storage: output register (`oreg`, `sel`) plus skid register (`skid`). States `ST_EMPTY` (nothing held), `ST_ONE` (oreg valid), `ST_TWO` (oreg and skid valid).
- Transitions, with in = input transfer and out = output transfer:
  - EMPTY: in goes to ONE (load oreg).
  - ONE: in & !out goes to TWO (load skid). out & !in goes to EMPTY. in & out stays ONE (reload oreg from input).
  - TWO: out goes to ONE (oreg takes skid). in cannot occur, because `in_ready` is 0.
- `in_ready` is the registered value of (next state != ST_TWO).
- `ready_q[N-1:0]` is `out_ready` registered every cycle; reset value 0.
- Target selection whenever oreg loads:
  - `start = (ptr+1) mod N`.
  - `sel` = first set bit of `ready_q` at or after `start`, wrapping.
  - If `ready_q` is all zero, `sel = start`.
  - `ptr <= sel`.
- Once `out_valid[sel]` rises, `sel` and `oreg` stay frozen until that channel handshakes. There is no retargeting and no drop.
- `out_valid[i] = (state != ST_EMPTY) & (sel == i)`, driven from registers.
- Ordering: items leave in input order. Items routed to one channel arrive in order.
- `out_ready[j]` for j ≠ `sel` is ignored, apart from sampling into `ready_q`.

## Timing
- Reset values:
  - state `ST_EMPTY`; all `out_valid` 0; `oreg`/`skid` data 0.
  - `sel` 0; `ptr` N-1, so the first pick starts at channel 0.
  - `ready_q` 0; `in_ready` 1.
- Latency: an item accepted at edge t drives `out_valid` from cycle t+1.
- Throughput: 1 item/cycle while the selected consumer holds ready.
- `in_ready` falls the cycle after the skid fills. It rises the cycle after an output transfer in `ST_TWO`.
- Simultaneous in & out in `ST_ONE`: no bubble. The new item is offered next cycle to a freshly selected channel.
- Selection uses `ready_q` (one cycle stale). A consumer that drops ready after being picked just stalls; the item still goes to it.
- N=1: `sel`/`ptr` are constant 0; the block behaves as a 2-deep pipeline FIFO.
- Reset mid-operation: held items are discarded and outputs return to reset values asynchronously. No partial transfer completes after reset.

## Structure
- Package `dispatcher_pkg`: `typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} disp_state_t;` plus a `ptr_w(N)` function.
- Sub-module `rr_pick_n #(N)`: combinational; inputs `cand[N-1:0]`, `start[PTR_W-1:0]`; outputs `pick`, `found`. It rotates by `start`, finds the lowest set bit and un-rotates. Reusable by other dispatch blocks.
- Top module holds the FSM, data registers, `ptr`, `ready_q` and the output fan-out.

## Test plan
- N=4, all `out_ready`=1, 8 back-to-back items 0x10..0x17: channels 0,1,2,3,0,1,2,3; one item/cycle; first `out_valid` one cycle after the first accept.
- N=4, only `out_ready[2]`=1 (steady), 4 items: all go to channel 2. `out_valid[0,1,3]` never rise.
- N=4, all `out_ready`=0, push 0xAA then 0xBB: `out_valid[0]` holds 0xAA stable and the skid holds 0xBB. `in_ready`=0 from the cycle after 0xBB is accepted. Raising `out_ready[0]` delivers 0xAA, then offers 0xBB on a fresh pick, and `in_ready` returns to 1.
- Picked consumer drops ready after selection (ch1 picked, `out_ready[1]`=0 for 5 cycles, others ready): `out_valid[1]` and data stay stable for 5 cycles with no retarget; delivery happens when ch1 is ready.
- Assert `rst` low in `ST_TWO`: `out_valid` goes all 0 and `in_ready` goes 1 immediately. After release, the first item goes to channel 0.
- N=1: 16 random items with random `out_ready`: in-order delivery, no loss or duplication, `in_ready` low only when 2 items are held.
